// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants and types for the instruction-fetch stage.
//   INST_ADDR_W / INST_DATA_W : default instruction address / data widths
//   INST_BYTES                : PC increment per instruction (alignment unit)
//   RESET_PC_DEF              : first fetch address after reset
//   CHIP_ENABLE / CHIP_DISABLE: ROM chip-enable levels
//   ZERO_DOUBLE_WORD          : all-zero instruction word
//   fetch_state_e             : fetch FSM encoding (IDLE / RUN / HALT)
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 64;
  localparam int INST_BYTES  = 8;

  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF     = 32'h0000_0000;
  localparam logic                   CHIP_ENABLE      = 1'b1;
  localparam logic                   CHIP_DISABLE     = 1'b0;
  localparam logic [INST_DATA_W-1:0] ZERO_DOUBLE_WORD = 64'h0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_RUN  = 2'b01,
    FETCH_HALT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Groups the ROM access bus and the IF/ID output handshake of the fetch stage.
//   rom_ce / rom_addr : fetch -> ROM request
//   rom_inst          : ROM -> fetch data (combinational from rom_addr)
//   id_valid/id_pc/id_inst/id_misalign : fetch -> decode entry
//   id_ready          : decode -> fetch acceptance
// Modports: master = fetch stage, slave = ROM + decode side.
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
);

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_misalign;
  logic              id_ready;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst, id_misalign,
    input  rom_inst, id_ready
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst, id_misalign,
    output rom_inst, id_ready
  );

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// inst_fetch_if_id_reg
// IF/ID output register with valid/ready hold.
//   clk, rst        : clock, asynchronous active-low reset
//   kill            : drop the held entry (redirect), highest priority
//   load            : capture ld_pc/ld_inst/ld_misalign as a new valid entry
//   ready           : consumer accepts the entry this cycle
//   valid/pc/inst/misalign : registered entry outputs
// -----------------------------------------------------------------------------
module inst_fetch_if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              load,
  input  logic              ready,
  input  logic [ADDR_W-1:0] ld_pc,
  input  logic [INST_W-1:0] ld_inst,
  input  logic              ld_misalign,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              misalign
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              misalign_q, misalign_d;

  // Next-entry selection: kill beats load, load beats consume.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    if (kill) begin
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = ld_pc;
      inst_d     = ld_inst;
      misalign_d = ld_misalign;
    end else if (valid_q && ready) begin
      // Consumed with nothing to replace it: the stage goes empty.
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else begin
      valid_d    = valid_q;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      misalign_q <= misalign_d;
    end
  end

  assign valid    = valid_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign misalign = misalign_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage: holds the PC, drives the ROM and fills the IF/ID
// register. Handles branch redirect, exception flush and misaligned targets.
//   clk, rst      : clock, asynchronous active-low reset
//   bus (master)  : ROM request/data and IF/ID handshake (see inst_fetch_if)
//   branch_flag / branch_target : redirect from execute (no delay slot)
//   flush / flush_pc            : exception flush, highest priority
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_W,
  parameter int                INST_W     = INST_DATA_W,
  parameter int                INST_BYTES = inst_fetch_pkg::INST_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_if.master      bus,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rom_ce_q, rom_ce_d;

  logic              adv_s;
  logic              load_s;
  logic              kill_s;
  logic [INST_W-1:0] ld_inst_s;
  logic              ld_misalign_s;
  logic              id_valid_s;

  assign adv_s = !id_valid_s || bus.id_ready;

  // Next state / PC / IF-ID control: flush > branch > normal sequencing.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_s        = 1'b0;
    kill_s        = 1'b0;
    ld_inst_s     = bus.rom_inst;
    ld_misalign_s = 1'b0;
    if (flush) begin
      pc_d    = flush_pc;
      kill_s  = 1'b1;
      state_d = FETCH_RUN;
    end else if (branch_flag && (state_q != FETCH_HALT)) begin
      pc_d    = branch_target;
      kill_s  = 1'b1;
      state_d = FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          state_d = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (adv_s) begin
            load_s = 1'b1;
            if ((pc_q & ALIGN_MASK) != '0) begin
              // Misaligned target: emit a trap marker instead of a ROM word.
              ld_inst_s     = ZERO_DOUBLE_WORD[INST_W-1:0];
              ld_misalign_s = 1'b1;
              state_d       = FETCH_HALT;
            end else begin
              pc_d = pc_q + PC_STEP;
            end
          end else begin
            load_s = 1'b0;
          end
        end
        FETCH_HALT: begin
          state_d = FETCH_HALT;
        end
        default: begin
          state_d = FETCH_IDLE;
        end
      endcase
    end
    // The ROM is only enabled for an aligned address while running.
    rom_ce_d = ((state_d == FETCH_RUN) && ((pc_d & ALIGN_MASK) == '0))
               ? CHIP_ENABLE : CHIP_DISABLE;
  end

  // FSM state, PC and registered chip enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      rom_ce_q <= CHIP_DISABLE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rom_ce_q <= rom_ce_d;
    end
  end

  assign bus.rom_ce   = rom_ce_q;
  assign bus.rom_addr = pc_q;
  assign bus.id_valid = id_valid_s;

  inst_fetch_if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .kill        (kill_s),
    .load        (load_s),
    .ready       (bus.id_ready),
    .ld_pc       (pc_q),
    .ld_inst     (ld_inst_s),
    .ld_misalign (ld_misalign_s),
    .valid       (id_valid_s),
    .pc          (bus.id_pc),
    .inst        (bus.id_inst),
    .misalign    (bus.id_misalign)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed vector table, an asynchronous-reset sequence, and randomized
// stimulus checked against a cycle-level behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;

  int n_cmp;
  int n_bad;

  inst_fetch_if #(.ADDR_W(32), .INST_W(64)) bus ();

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  // ROM contents are a fixed function of the address.
  function automatic logic [63:0] rom_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_0F0F, ~a};
  endfunction

  assign bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr) : 64'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs; entry fields only matter while the entry is valid.
  task automatic check_outputs(input string tag, input logic e_val, input logic [31:0] e_pc,
                               input logic e_mis, input logic e_ce, input logic [31:0] e_addr);
    check({tag, ".id_valid"}, 64'(bus.id_valid), 64'(e_val));
    check({tag, ".rom_ce"},   64'(bus.rom_ce),   64'(e_ce));
    check({tag, ".rom_addr"}, 64'(bus.rom_addr), 64'(e_addr));
    if (e_val) begin
      check({tag, ".id_pc"},       64'(bus.id_pc),       64'(e_pc));
      check({tag, ".id_misalign"}, 64'(bus.id_misalign), 64'(e_mis));
      check({tag, ".id_inst"},     bus.id_inst,          e_mis ? 64'h0 : rom_word(e_pc));
    end
  endtask

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] bt;
    logic        rdy;
    logic        e_val;
    logic [31:0] e_pc;
    logic        e_mis;
    logic        e_ce;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic br,
                              input logic [31:0] bt, input logic rdy, input logic e_val,
                              input logic [31:0] e_pc, input logic e_mis, input logic e_ce,
                              input logic [31:0] e_addr);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.br = br; v.bt = bt; v.rdy = rdy;
    v.e_val = e_val; v.e_pc = e_pc; v.e_mis = e_mis; v.e_ce = e_ce; v.e_addr = e_addr;
    return v;
  endfunction

  // Behavioural model: mode 0 = waiting to start, 1 = fetching, 2 = halted on trap.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_epc;
  logic        m_emis;

  task automatic model_step(input logic fl, input logic [31:0] fpc, input logic br,
                            input logic [31:0] bt, input logic rdy);
    bit accept;
    accept = !m_v || rdy;
    if (fl) begin
      m_pc = fpc; m_v = 1'b0; m_mode = 1;
    end else if (br && m_mode != 2) begin
      m_pc = bt; m_v = 1'b0; m_mode = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (accept) begin
        m_v   = 1'b1;
        m_epc = m_pc;
        if (m_pc % 8 != 0) begin
          m_emis = 1'b1; m_mode = 2;
        end else begin
          m_emis = 1'b0; m_pc = m_pc + 32'd8;
        end
      end
    end else begin
      if (m_v && rdy) m_v = 1'b0;
    end
  endtask

  vec_t tbl[24];

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //            fl   fpc           br   bt            rdy  val  pc            mis  ce   addr
    tbl[0]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0);
    tbl[1]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0,       1'b0, 1'b1, 32'h8);
    tbl[2]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h8,       1'b0, 1'b1, 32'h10);
    tbl[3]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h10,      1'b0, 1'b1, 32'h18);
    tbl[4]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h10,      1'b0, 1'b1, 32'h18);
    tbl[5]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h10,      1'b0, 1'b1, 32'h18);
    tbl[6]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h10,      1'b0, 1'b1, 32'h18);
    tbl[7]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h18,      1'b0, 1'b1, 32'h20);
    tbl[8]  = mk(1'b0, 32'h0,       1'b1, 32'h40,      1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h40);
    tbl[9]  = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h40,      1'b0, 1'b1, 32'h48);
    tbl[10] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h48,      1'b0, 1'b1, 32'h50);
    tbl[11] = mk(1'b1, 32'h100,     1'b1, 32'h40,      1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h100);
    tbl[12] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h100,     1'b0, 1'b1, 32'h108);
    tbl[13] = mk(1'b0, 32'h0,       1'b1, 32'h44,      1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h44);
    tbl[14] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h44);
    tbl[15] = mk(1'b0, 32'h0,       1'b1, 32'h40,      1'b0, 1'b1, 32'h44,      1'b1, 1'b0, 32'h44);
    tbl[16] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h44);
    tbl[17] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h44);
    tbl[18] = mk(1'b1, 32'h80,      1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h80);
    tbl[19] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h80,      1'b0, 1'b1, 32'h88);
    tbl[20] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h88,      1'b0, 1'b1, 32'h90);
    tbl[21] = mk(1'b0, 32'h0,       1'b1, 32'hFFFFFFF8, 1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'hFFFFFFF8);
    tbl[22] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b1, 32'h0);
    tbl[23] = mk(1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0,       1'b0, 1'b1, 32'h8);

    rst = 1'b0;
    branch_flag = 1'b0; branch_target = 32'h0;
    flush = 1'b0; flush_pc = 32'h0;
    bus.id_ready = 1'b0;

    // Reset values, then release between edges.
    #2;
    check("reset.id_valid",    64'(bus.id_valid),    64'h0);
    check("reset.id_pc",       64'(bus.id_pc),       64'h0);
    check("reset.id_inst",     bus.id_inst,          64'h0);
    check("reset.id_misalign", 64'(bus.id_misalign), 64'h0);
    check("reset.rom_ce",      64'(bus.rom_ce),      64'h0);
    check("reset.rom_addr",    64'(bus.rom_addr),    64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table: inputs before an edge, outputs after it.
    for (int i = 0; i < 24; i++) begin
      flush = tbl[i].fl; flush_pc = tbl[i].fpc;
      branch_flag = tbl[i].br; branch_target = tbl[i].bt;
      bus.id_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].e_val, tbl[i].e_pc,
                    tbl[i].e_mis, tbl[i].e_ce, tbl[i].e_addr);
      flush = 1'b0; branch_flag = 1'b0;
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("areset.id_valid",    64'(bus.id_valid),    64'h0);
    check("areset.id_pc",       64'(bus.id_pc),       64'h0);
    check("areset.id_inst",     bus.id_inst,          64'h0);
    check("areset.id_misalign", 64'(bus.id_misalign), 64'h0);
    check("areset.rom_ce",      64'(bus.rom_ce),      64'h0);
    check("areset.rom_addr",    64'(bus.rom_addr),    64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    m_mode = 0; m_pc = 32'h0; m_v = 1'b0; m_epc = 32'h0; m_emis = 1'b0;

    // Randomized stimulus against the model; the first cycles show the restart.
    for (int i = 0; i < 400; i++) begin
      logic        fl, br, rdy;
      logic [31:0] fpc, bt;
      fl  = ($urandom_range(0, 19) == 0);
      br  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      fpc = 32'($urandom_range(0, 4095)) << 3;
      bt  = 32'($urandom_range(0, 4095)) << 3;
      if ($urandom_range(0, 5) == 0) bt = bt | 32'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) fpc = fpc | 32'($urandom_range(1, 7));
      if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFF0;
      if (i < 4) begin
        fl = 1'b0; br = 1'b0; rdy = 1'b1;
      end
      flush = fl; flush_pc = fpc;
      branch_flag = br; branch_target = bt;
      bus.id_ready = rdy;
      model_step(fl, fpc, br, bt, rdy);
      @(posedge clk);
      #1;
      check_outputs($sformatf("rnd%0d", i), m_v, m_epc, m_emis,
                    (m_mode == 1) && (m_pc % 8 == 0), m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Drives the instruction ROM and feeds decode: the requesting end of the ROM's ce/addr/inst interface.
- Holds the PC and issues rom_ce/rom_addr. The ROM returns rom_inst combinationally in the same cycle.
- Registers {pc, inst} into an IF/ID output stage with a valid/ready handshake.
- Handles branch redirect and exception flush, and traps misaligned targets.

Parameters:
- ADDR_W, 32: instruction address width (matches `InstAddrBus).
- INST_W, 64: instruction width (matches `InstBus).
- INST_BYTES, 8: PC increment per instruction. Addresses must be 8-byte aligned.
- RESET_PC, 32'h0: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- rom_ce  out  1  ROM chip enable (`ChipEnable / `ChipDisable).
- rom_addr  out  ADDR_W  ROM byte address; equals pc.
- rom_inst  in  INST_W  ROM data, combinational from rom_addr. Zero when rom_ce is disabled.
- id_ready  in  1  decode accepts the IF/ID entry this cycle.
- branch_flag  in  1  redirect request from execute; no delay slot.
- branch_target  in  ADDR_W  redirect address.
- flush  in  1  exception/pipeline flush from control.
- flush_pc  in  ADDR_W  handler address used with flush.
- id_valid  out  1  IF/ID entry valid.
- id_pc  out  ADDR_W  PC of the IF/ID instruction.
- id_inst  out  INST_W  instruction in IF/ID.
- id_misalign  out  1  IF/ID entry is a misaligned-fetch trap marker.

Behaviour:
- Reset (rst=0, asynchronous), all outputs at reset values:
  - state=IDLE, pc=RESET_PC, rom_ce=`ChipDisable.
  - id_valid=0, id_pc=0, id_inst=`ZeroDoubleWord, id_misalign=0.
- FSM states IDLE, RUN, HALT. rom_ce is a registered output.
- IDLE:
  - rom_ce=0.
  - First clock edge with rst=1 → RUN, rom_ce=1.
  - Redirects in IDLE still update pc; the priority rules below apply.
- RUN:
  - rom_addr=pc, rom_ce=1.
  - Advance condition: adv = !id_valid || id_ready.
  - If adv and no redirect: id_inst<=rom_inst, id_pc<=pc, id_valid<=1, id_misalign<=0, pc<=pc+INST_BYTES.
  - If !adv: pc and IF/ID hold unchanged. rom_inst is not re-latched.
  - PC increment wraps modulo 2^ADDR_W: 32'hFFFFFFF8 + 8 → 32'h0, no flag.
- Redirect priority: flush > branch_flag > normal advance.
  - flush: pc<=flush_pc, id_valid<=0, id_misalign<=0. Applies regardless of id_ready or state; exits HALT → RUN.
  - branch_flag (no flush): pc<=branch_target, id_valid<=0 (wrong-path entry killed). Ignored in HALT.
  - Penalty: exactly one bubble cycle. The target is fetched the cycle after the redirect and appears in IF/ID one edge later.
- Misalignment (new pc[2:0]!=0 after any redirect):
  - Next RUN cycle: no ROM access, rom_ce=0.
  - When adv: id_valid<=1, id_pc<=pc, id_inst<=0, id_misalign<=1; state → HALT.
- HALT:
  - rom_ce=0, pc frozen.
  - The IF/ID entry stays until consumed (id_ready clears id_valid), then stays empty.
  - Only flush leaves HALT.
- id_ready while id_valid=0 is ignored. id_valid never drops without id_ready, flush or branch.

Decomposition:
- defines.v, shared by all modules:
  - existing `InstAddrBus, `InstBus, `ChipEnable, `ChipDisable, `ZeroDoubleWord;
  - new `InstBytes (8), `ResetPC;
  - new 2-bit state encodings `FetchIdle, `FetchRun, `FetchHalt.
- One sub-module, if_id_reg: the IF/ID output register with valid/ready hold and kill inputs.
- PC/FSM logic stays in inst_fetch.

Test Plan:
- Reset then release, id_ready=1 → rom_ce=0 in the first cycle. Then id_pc=0,8,16,… on successive cycles, with id_inst equal to ROM words 0,1,2.
- id_ready=0 for 3 cycles while id_valid=1 with id_pc=16 → id_pc=16 and id_inst held, pc=24 frozen. Release → id_pc=24 next edge.
- branch_flag=1, target=32'h40 while id_valid=1 and id_ready=0 → id_valid=0 next edge, then id_pc=32'h40 one edge later.
- flush=1, flush_pc=32'h100 together with branch_flag=1, target=32'h40 → flush wins, next valid id_pc=32'h100.
- branch_target=32'h44 → one entry with id_misalign=1, id_pc=32'h44, id_inst=0, rom_ce=0. HALT ignores a later branch; flush to 32'h80 resumes fetch.
- rst dropped mid-stream with id_valid=1 → all outputs reset immediately without a clock edge. After release, fetch restarts at RESET_PC.
